// File: rtl/reset_sequencer_if.sv
// Handshake and reset-output bundle for reset_sequencer.
// slave = sequencer side, master = requester / harness side.
interface reset_sequencer_if #(
  parameter int N_DOMAINS = 4
);
  logic                 req;
  logic                 ack;
  logic                 busy;
  logic                 done;
  logic [N_DOMAINS-1:0] resets;

  modport slave  (input  req, output ack, busy, done, resets);
  modport master (output req, input  ack, busy, done, resets);
endinterface

// File: rtl/reset_sequencer.sv
// Multi-domain reset sequencer: hold all resets, then release lowest index first.
// Define RESET_SEQUENCER_REQ_EN to enable the req/ack re-sequence path.
module reset_sequencer #(
  parameter int          N_DOMAINS    = 4,
  parameter logic [31:0] ASSERT_COUNT = 32'd20,
  parameter logic [31:0] RELEASE_GAP  = 32'd4
) (
  input  logic              clock,
  input  logic              reset_n,
  reset_sequencer_if.slave  bus
);
  localparam int IW = (N_DOMAINS > 1) ? $clog2(N_DOMAINS + 1) : 1;

  localparam logic [1:0] HOLD    = 2'd0;
  localparam logic [1:0] RELEASE = 2'd1;
  localparam logic [1:0] RUN     = 2'd2;

  localparam logic [31:0]   HOLD_LAST = ASSERT_COUNT - 32'd1;
  localparam logic [31:0]   GAP_LAST  = RELEASE_GAP - 32'd1;
  localparam logic [IW-1:0] LAST_IDX  = IW'(N_DOMAINS - 1);

`ifdef RESET_SEQUENCER_REQ_EN
  localparam bit REQ_EN = 1'b1;
`else
  localparam bit REQ_EN = 1'b0;
`endif

  logic [1:0]           state;
  logic [31:0]          cnt;
  logic [IW-1:0]        idx;
  logic [N_DOMAINS-1:0] rst_q;
  logic                 busy_q, done_q, ack_q;

  logic rel_stb, last_stb, restart;

  // idx is 0 throughout HOLD, so the first release reuses the same strobe path
  assign rel_stb  = ((state == HOLD)    && (cnt == HOLD_LAST)) ||
                    ((state == RELEASE) && (cnt == GAP_LAST));
  assign last_stb = rel_stb && (idx == LAST_IDX);
  assign restart  = REQ_EN && (state == RUN) && bus.req;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state  <= HOLD;
      cnt    <= 32'd0;
      idx    <= '0;
      rst_q  <= '1;
      busy_q <= 1'b1;
      done_q <= 1'b0;
      ack_q  <= 1'b0;
    end else begin
      ack_q <= restart;
      case (state)
        HOLD, RELEASE: begin
          if (rel_stb) begin
            cnt <= 32'd0;
            idx <= idx + IW'(1);
            for (int i = 0; i < N_DOMAINS; i++)
              if (idx == IW'(i)) rst_q[i] <= 1'b0;
            if (last_stb) begin
              state  <= RUN;
              busy_q <= 1'b0;
              done_q <= 1'b1;
            end else begin
              state <= RELEASE;
            end
          end else begin
            cnt <= cnt + 32'd1;
          end
        end
        RUN: begin
          if (restart) begin
            state  <= HOLD;
            cnt    <= 32'd0;
            idx    <= '0;
            rst_q  <= '1;
            busy_q <= 1'b1;
            done_q <= 1'b0;
          end
        end
        default: state <= HOLD;
      endcase
    end
  end

  assign bus.resets = rst_q;
  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.ack    = ack_q;
endmodule

// File: tb/tb_reset_sequencer.sv
// Directed bench: default, single-domain/hold-1 and gap-1 instances on one clock.
module tb_reset_sequencer;
  logic clock = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  reset_sequencer_if #(.N_DOMAINS(4)) b0 ();
  reset_sequencer_if #(.N_DOMAINS(1)) b1 ();
  reset_sequencer_if #(.N_DOMAINS(4)) b2 ();

  reset_sequencer #(.N_DOMAINS(4), .ASSERT_COUNT(32'd20), .RELEASE_GAP(32'd4))
    u0 (.clock(clock), .reset_n(reset_n), .bus(b0));
  reset_sequencer #(.N_DOMAINS(1), .ASSERT_COUNT(32'd1), .RELEASE_GAP(32'd4))
    u1 (.clock(clock), .reset_n(reset_n), .bus(b1));
  reset_sequencer #(.N_DOMAINS(4), .ASSERT_COUNT(32'd20), .RELEASE_GAP(32'd1))
    u2 (.clock(clock), .reset_n(reset_n), .bus(b2));

  typedef struct {
    int         e;
    int         dut;
    logic [3:0] r;
    logic       d;
  } vec_t;

  vec_t tbl[$];
  int total = 0;
  int bad = 0;
  int edge_n = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, edge_n);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
    edge_n++;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    chk("rst_resets0", {28'd0, b0.resets}, 32'hf);
    chk("rst_busy0",   {31'd0, b0.busy}, 32'd1);
    chk("rst_done0",   {31'd0, b0.done}, 32'd0);
    chk("rst_ack0",    {31'd0, b0.ack}, 32'd0);
    chk("rst_resets1", {31'd0, b1.resets}, 32'd1);
    @(negedge clock);
    reset_n = 1'b1;
    edge_n = 0;
  endtask

  task automatic run_table();
    logic [3:0] r;
    logic       d, b;
    foreach (tbl[k]) begin
      while (edge_n < tbl[k].e) tick();
      case (tbl[k].dut)
        0:       begin r = b0.resets;         d = b0.done; b = b0.busy; end
        1:       begin r = {3'b0, b1.resets}; d = b1.done; b = b1.busy; end
        default: begin r = b2.resets;         d = b2.done; b = b2.busy; end
      endcase
      chk($sformatf("tbl%0d_resets", k), {28'd0, r}, {28'd0, tbl[k].r});
      chk($sformatf("tbl%0d_done", k),   {31'd0, d}, {31'd0, tbl[k].d});
      chk($sformatf("tbl%0d_busy", k),   {31'd0, b}, {31'd0, |tbl[k].r});
    end
  endtask

  task automatic add(input int e, input int dut, input logic [3:0] r, input logic d);
    vec_t v;
    v.e = e; v.dut = dut; v.r = r; v.d = d;
    tbl.push_back(v);
  endtask

  initial begin
    logic saw_ack;
    b0.req = 1'b0;
    b1.req = 1'b0;
    b2.req = 1'b0;

    add(1, 0, 4'b1111, 1'b0); add(1, 1, 4'b0000, 1'b1); add(1, 2, 4'b1111, 1'b0);
    add(10, 1, 4'b0000, 1'b1);
    add(19, 0, 4'b1111, 1'b0); add(19, 2, 4'b1111, 1'b0);
    add(20, 0, 4'b1110, 1'b0); add(20, 2, 4'b1110, 1'b0);
    add(21, 2, 4'b1100, 1'b0); add(22, 2, 4'b1000, 1'b0); add(23, 2, 4'b0000, 1'b1);
    add(23, 0, 4'b1110, 1'b0); add(24, 0, 4'b1100, 1'b0);
    add(27, 0, 4'b1100, 1'b0); add(28, 0, 4'b1000, 1'b0);
    add(31, 0, 4'b1000, 1'b0); add(32, 0, 4'b0000, 1'b1);
    add(35, 0, 4'b0000, 1'b1);

    do_reset();
    run_table();

    // re-sequence from RUN: req seen at edge 36
    b0.req = 1'b1;
    tick();
`ifdef RESET_SEQUENCER_REQ_EN
    chk("reseq_ack",    {31'd0, b0.ack}, 32'd1);
    chk("reseq_resets", {28'd0, b0.resets}, 32'hf);
    chk("reseq_done",   {31'd0, b0.done}, 32'd0);
    b0.req = 1'b0;
    tick();
    chk("reseq_ack_1cyc", {31'd0, b0.ack}, 32'd0);
    while (edge_n < 55) tick();
    chk("reseq_e19", {28'd0, b0.resets}, 32'hf);
    tick();
    chk("reseq_e20", {28'd0, b0.resets}, 32'he);
    while (edge_n < 60) tick();
    chk("reseq_e24", {28'd0, b0.resets}, 32'hc);
    while (edge_n < 64) tick();
    chk("reseq_e28", {28'd0, b0.resets}, 32'h8);
    while (edge_n < 68) tick();
    chk("reseq_e32", {28'd0, b0.resets}, 32'h0);
    chk("reseq_done_end", {31'd0, b0.done}, 32'd1);
`else
    chk("noreq_ack",    {31'd0, b0.ack}, 32'd0);
    chk("noreq_resets", {28'd0, b0.resets}, 32'h0);
    chk("noreq_done",   {31'd0, b0.done}, 32'd1);
    b0.req = 1'b0;
    tick();
    chk("noreq_ack2",   {31'd0, b0.ack}, 32'd0);
    chk("noreq_done2",  {31'd0, b0.done}, 32'd1);
`endif

    // request held while busy
    do_reset();
    while (edge_n < 4) tick();
    b0.req = 1'b1;
    saw_ack = 1'b0;
    while (edge_n < 32) begin
      tick();
      saw_ack = saw_ack | b0.ack;
    end
    chk("busy_no_ack", {31'd0, saw_ack}, 32'd0);
    tick();
`ifdef RESET_SEQUENCER_REQ_EN
    chk("busy_ack_e33", {31'd0, b0.ack}, 32'd1);
    b0.req = 1'b0;
    saw_ack = 1'b0;
    while (edge_n < 65) begin
      tick();
      saw_ack = saw_ack | b0.ack;
    end
    chk("busy_seq_done", {31'd0, b0.done}, 32'd1);
    chk("busy_seq_rst",  {28'd0, b0.resets}, 32'h0);
    while (edge_n < 75) begin
      tick();
      saw_ack = saw_ack | b0.ack;
    end
    chk("busy_single_seq", {31'd0, saw_ack}, 32'd0);
`else
    chk("busy_ack_e33", {31'd0, b0.ack}, 32'd0);
    b0.req = 1'b0;
    chk("busy_rst_e33", {28'd0, b0.resets}, 32'h0);
`endif

    // asynchronous reset mid-sequence
    do_reset();
    while (edge_n < 26) tick();
    chk("mid_pre", {28'd0, b0.resets}, 32'hc);
    reset_n = 1'b0;
    #1;
    chk("mid_async_resets", {28'd0, b0.resets}, 32'hf);
    chk("mid_async_done",   {31'd0, b0.done}, 32'd0);
    chk("mid_async_ack",    {31'd0, b0.ack}, 32'd0);
    chk("mid_async_busy",   {31'd0, b0.busy}, 32'd1);
    do_reset();
    run_table();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end
endmodule
